// File: rtl/mux_sweep_ctrl_if.sv
// Signal bundle between the mux sweep sequencer and its lab top level or bench.
// Datapath drive/return lines, sweep control and status, and the FSM debug view.
interface mux_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       mux_a;
  logic       mux_b;
  logic       mux_sel;
  logic       mux_z;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_fail;
  logic       fail_valid;
  logic [2:0] state_dbg;

  // Handshake: start is a one-cycle request sampled on the rising edge and
  // accepted only while busy=0 and done=0; done is a one-cycle completion
  // pulse, and pass/err_count/first_fail/fail_valid are valid whenever busy=0.
  modport master (
    output start, abort, mux_z,
    input  mux_a, mux_b, mux_sel, busy, done, pass,
    input  err_count, first_fail, fail_valid, state_dbg
  );

  modport slave (
    input  start, abort, mux_z,
    output mux_a, mux_b, mux_sel, busy, done, pass,
    output err_count, first_fail, fail_valid, state_dbg
  );
endinterface

// File: rtl/mux_sweep_ctrl.sv
// Exhaustive self-checking sweep of a 2:1 mux: drives all 8 {a,b,sel} vectors,
// waits SETTLE_CYC cycles, samples z against sel ? b : a and records results.
module mux_sweep_ctrl #(
  parameter int SETTLE_CYC = 2
) (
  input logic             clk,
  input logic             rst_n,
  mux_sweep_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;

  state_t     state, state_n;
  logic [2:0] v;
  logic [3:0] cnt;
  logic       mux_a, mux_b, mux_sel;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_fail;
  logic       fail_valid;

  logic       expected;
  logic       mismatch;
  logic [3:0] err_count_n;
  logic       abort_hit;

  // Golden value comes from the registered drive lines, which always equal v.
  always_comb begin
    expected    = mux_sel ? mux_b : mux_a;
    mismatch    = (state == SAMPLE) && (bus.mux_z != expected);
    err_count_n = err_count + {3'd0, mismatch};
    abort_hit   = bus.abort && (state != IDLE);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = APPLY;
      APPLY:   state_n = (SETTLE_CYC > 0) ? SETTLE : SAMPLE;
      SETTLE:  if (cnt == 4'd0) state_n = SAMPLE;
      SAMPLE:  state_n = (v == 3'd7) ? DONE : APPLY;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort_hit) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v          <= 3'd0;
      cnt        <= 4'd0;
      mux_a      <= 1'b0;
      mux_b      <= 1'b0;
      mux_sel    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 4'd0;
      first_fail <= 3'd0;
      fail_valid <= 1'b0;
    end else begin
      busy <= (state_n != IDLE) && (state_n != DONE);
      done <= (state_n == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            v          <= 3'd0;
            mux_a      <= 1'b0;
            mux_b      <= 1'b0;
            mux_sel    <= 1'b0;
            err_count  <= 4'd0;
            first_fail <= 3'd0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
          end
        end
        APPLY:  cnt <= SETTLE_LOAD;
        SETTLE: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        SAMPLE: begin
          // The sample is recorded even when an abort arrives in this cycle.
          err_count <= err_count_n;
          if (mismatch && !fail_valid) begin
            first_fail <= v;
            fail_valid <= 1'b1;
          end
          if (!abort_hit && (v != 3'd7)) begin
            v                         <= v + 3'd1;
            {mux_a, mux_b, mux_sel}   <= v + 3'd1;
          end
        end
        default: ;
      endcase
      if (state_n == DONE) pass <= (err_count_n == 4'd0);
      if (abort_hit)       pass <= 1'b0;
    end
  end

  assign bus.mux_a      = mux_a;
  assign bus.mux_b      = mux_b;
  assign bus.mux_sel    = mux_sel;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.err_count  = err_count;
  assign bus.first_fail = first_fail;
  assign bus.fail_valid = fail_valid;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_mux_sweep_ctrl.sv
// Directed bench for mux_sweep_ctrl: a SETTLE_CYC=2 instance for the main
// scenarios and a SETTLE_CYC=0 instance for the short-sweep/ignored-start case.
module tb_mux_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // 0 = correct mux, 1 = z stuck at 0, 2 = inverted mux
  int mode2 = 0;
  int mode0 = 0;

  mux_sweep_ctrl_if if2 ();
  mux_sweep_ctrl_if if0 ();

  function automatic logic mux_model(input int mode, input logic a, input logic b, input logic s);
    logic good;
    good = s ? b : a;
    case (mode)
      1:       return 1'b0;
      2:       return ~good;
      default: return good;
    endcase
  endfunction

  assign if2.mux_z = mux_model(mode2, if2.mux_a, if2.mux_b, if2.mux_sel);
  assign if0.mux_z = mux_model(mode0, if0.mux_a, if0.mux_b, if0.mux_sel);

  mux_sweep_ctrl #(.SETTLE_CYC(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  mux_sweep_ctrl #(.SETTLE_CYC(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

  // Pulses start on the SETTLE_CYC=2 instance and watches 40 cycles; index j is
  // the falling edge following the j-th rising edge after the start edge.
  task automatic run_sweep2(output int busy_n, output int done_n, output int done_at,
                            output int order_err);
    busy_n = 0; done_n = 0; done_at = -1; order_err = 0;
    @(negedge clk) if2.start = 1'b1;
    @(negedge clk) if2.start = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (j > 0) @(negedge clk);
      if (if2.busy) busy_n++;
      if (if2.done) begin done_n++; done_at = j; end
      if (j < 32 && {if2.mux_a, if2.mux_b, if2.mux_sel} !== 3'(j / 4)) order_err++;
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({if2.mux_a, if2.mux_b, if2.mux_sel, if2.busy, if2.done, if2.pass} !== 6'b0 ||
        if2.err_count !== 4'd0 || if2.first_fail !== 3'd0 || if2.fail_valid !== 1'b0 ||
        if2.state_dbg !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b pass=%b err=%0d ff=%0d fv=%b st=%0d, want all 0",
               if2.busy, if2.done, if2.pass, if2.err_count, if2.first_fail, if2.fail_valid, if2.state_dbg);
    end
  endtask

  task automatic test_good_sweep();
    int busy_n, done_n, done_at, order_err;
    mode2 = 0;
    run_sweep2(busy_n, done_n, done_at, order_err);
    tests_run++;
    if (busy_n !== 32) begin tests_failed++; $display("FAIL good_busy_cycles: got %0d want 32", busy_n); end
    tests_run++;
    if (done_n !== 1 || done_at !== 32) begin
      tests_failed++; $display("FAIL good_done_pulse: count %0d at %0d, want 1 at 32", done_n, done_at);
    end
    tests_run++;
    if (order_err !== 0) begin tests_failed++; $display("FAIL good_vector_order: %0d bad cycles, want 0", order_err); end
    tests_run++;
    if (if2.pass !== 1'b1 || if2.err_count !== 4'd0 || if2.fail_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL good_result: pass=%b err=%0d fv=%b, want 1 0 0", if2.pass, if2.err_count, if2.fail_valid);
    end
    tests_run++;
    if ({if2.mux_a, if2.mux_b, if2.mux_sel} !== 3'b111) begin
      tests_failed++; $display("FAIL good_hold_inputs: got %b want 111", {if2.mux_a, if2.mux_b, if2.mux_sel});
    end
  endtask

  task automatic test_stuck_zero();
    int busy_n, done_n, done_at, order_err;
    mode2 = 1;
    run_sweep2(busy_n, done_n, done_at, order_err);
    tests_run++;
    if (if2.err_count !== 4'd4 || if2.first_fail !== 3'b011 || if2.fail_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stuck0_errors: err=%0d ff=%b fv=%b, want 4 011 1", if2.err_count, if2.first_fail, if2.fail_valid);
    end
    tests_run++;
    if (if2.pass !== 1'b0 || done_n !== 1 || done_at !== 32) begin
      tests_failed++;
      $display("FAIL stuck0_done: pass=%b done %0d at %0d, want pass 0 done 1 at 32", if2.pass, done_n, done_at);
    end
  endtask

  task automatic test_inverted();
    int busy_n, done_n, done_at, order_err;
    mode2 = 2;
    run_sweep2(busy_n, done_n, done_at, order_err);
    tests_run++;
    if (if2.err_count !== 4'd8 || if2.first_fail !== 3'b000 || if2.fail_valid !== 1'b1 || if2.pass !== 1'b0) begin
      tests_failed++;
      $display("FAIL inverted_result: err=%0d ff=%b fv=%b pass=%b, want 8 000 1 0",
               if2.err_count, if2.first_fail, if2.fail_valid, if2.pass);
    end
  endtask

  task automatic test_abort();
    int done_n = 0;
    mode2 = 0;
    // abort while idle must not disturb the last (failing) result
    @(negedge clk) if2.abort = 1'b1;
    @(negedge clk) if2.abort = 1'b0;
    tests_run++;
    if (if2.busy !== 1'b0 || if2.err_count !== 4'd8) begin
      tests_failed++; $display("FAIL abort_idle: busy=%b err=%0d, want 0 8", if2.busy, if2.err_count);
    end
    if2.start = 1'b1;
    @(negedge clk) if2.start = 1'b0;   // j=0
    repeat (13) @(negedge clk);        // j=13: vector 3, first settle cycle
    tests_run++;
    if (if2.state_dbg !== 3'd2 || {if2.mux_a, if2.mux_b, if2.mux_sel} !== 3'b011) begin
      tests_failed++;
      $display("FAIL abort_setup: st=%0d vec=%b, want 2 011", if2.state_dbg, {if2.mux_a, if2.mux_b, if2.mux_sel});
    end
    if2.abort = 1'b1;
    @(negedge clk) if2.abort = 1'b0;
    tests_run++;
    if (if2.busy !== 1'b0 || if2.state_dbg !== 3'd0 || if2.pass !== 1'b0 || if2.err_count !== 4'd0 ||
        {if2.mux_a, if2.mux_b, if2.mux_sel} !== 3'b011) begin
      tests_failed++;
      $display("FAIL abort_mid: busy=%b st=%0d pass=%b err=%0d vec=%b, want 0 0 0 0 011",
               if2.busy, if2.state_dbg, if2.pass, if2.err_count, {if2.mux_a, if2.mux_b, if2.mux_sel});
    end
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (if2.done) done_n++;
    end
    tests_run++;
    if (done_n !== 0) begin tests_failed++; $display("FAIL abort_no_done: got %0d pulses want 0", done_n); end
    // start and abort together in idle: start wins
    if2.start = 1'b1; if2.abort = 1'b1;
    @(negedge clk) begin if2.start = 1'b0; if2.abort = 1'b0; end
    tests_run++;
    if (if2.busy !== 1'b1 || if2.state_dbg !== 3'd1) begin
      tests_failed++; $display("FAIL start_beats_abort: busy=%b st=%0d, want 1 1", if2.busy, if2.state_dbg);
    end
    if2.abort = 1'b1;
    @(negedge clk) if2.abort = 1'b0;
  endtask

  task automatic test_abort_last();
    int done_n = 0;
    mode2 = 1;
    @(negedge clk) if2.start = 1'b1;
    @(negedge clk) if2.start = 1'b0;   // j=0
    repeat (31) @(negedge clk);        // j=31: SAMPLE of vector 7
    tests_run++;
    if (if2.state_dbg !== 3'd3 || {if2.mux_a, if2.mux_b, if2.mux_sel} !== 3'b111) begin
      tests_failed++; $display("FAIL abort_last_setup: st=%0d, want 3 at vector 111", if2.state_dbg);
    end
    if2.abort = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk) if2.abort = 1'b0;
      if (if2.done) done_n++;
    end
    tests_run++;
    if (done_n !== 0 || if2.pass !== 1'b0 || if2.busy !== 1'b0 || if2.err_count !== 4'd4) begin
      tests_failed++;
      $display("FAIL abort_last: done=%0d pass=%b busy=%b err=%0d, want 0 0 0 4",
               done_n, if2.pass, if2.busy, if2.err_count);
    end
  endtask

  task automatic test_reset_mid();
    int busy_n, done_n, done_at, order_err;
    mode2 = 1;
    @(negedge clk) if2.start = 1'b1;
    @(negedge clk) if2.start = 1'b0;   // j=0
    repeat (21) @(negedge clk);        // j=21: vector 5, errors already recorded
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({if2.mux_a, if2.mux_b, if2.mux_sel, if2.busy, if2.done, if2.pass} !== 6'b0 ||
        if2.err_count !== 4'd0 || if2.first_fail !== 3'd0 || if2.fail_valid !== 1'b0 ||
        if2.state_dbg !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: vec=%b busy=%b err=%0d ff=%0d fv=%b st=%0d, want all 0",
               {if2.mux_a, if2.mux_b, if2.mux_sel}, if2.busy, if2.err_count, if2.first_fail,
               if2.fail_valid, if2.state_dbg);
    end
    @(negedge clk) rst_n = 1'b1;
    mode2 = 0;
    run_sweep2(busy_n, done_n, done_at, order_err);
    tests_run++;
    if (if2.pass !== 1'b1 || done_n !== 1 || done_at !== 32 || order_err !== 0) begin
      tests_failed++;
      $display("FAIL reset_recover: pass=%b done %0d at %0d order_err=%0d, want 1 1 32 0",
               if2.pass, done_n, done_at, order_err);
    end
  endtask

  task automatic test_back_to_back();
    int busy_n = 0, done_n = 0, done_at = -1, order_err = 0;
    mode0 = 0;
    @(negedge clk) if0.start = 1'b1;
    @(negedge clk) if0.start = 1'b0;
    for (int j = 0; j < 25; j++) begin
      if (j > 0) @(negedge clk);
      if (if0.busy) busy_n++;
      if (if0.done) begin done_n++; done_at = j; end
      if (j < 16 && {if0.mux_a, if0.mux_b, if0.mux_sel} !== 3'(j / 2)) order_err++;
      // extra starts while busy and in DONE must be ignored
      if0.start = (j == 3 || j == 9 || j == 16);
    end
    if0.start = 1'b0;
    tests_run++;
    if (done_n !== 1 || done_at !== 16) begin
      tests_failed++; $display("FAIL settle0_done: count %0d at %0d, want 1 at 16", done_n, done_at);
    end
    tests_run++;
    if (busy_n !== 16 || order_err !== 0) begin
      tests_failed++; $display("FAIL settle0_busy_order: busy %0d order_err %0d, want 16 0", busy_n, order_err);
    end
    tests_run++;
    if (if0.pass !== 1'b1 || if0.err_count !== 4'd0) begin
      tests_failed++; $display("FAIL settle0_pass: pass=%b err=%0d, want 1 0", if0.pass, if0.err_count);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if2.start = 1'b0; if2.abort = 1'b0;
    if0.start = 1'b0; if0.abort = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    test_good_sweep();
    test_stuck_zero();
    test_inverted();
    test_abort();
    test_abort_last();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mux_sweep_ctrl.md
Name: mux_sweep_ctrl

Overview:
- Self-checking sequencer for the 3-input 2:1 mux datapath, where z = (a & ~sel) | (sel & b).
- On a start pulse it drives all 8 input vectors onto the datapath inputs. It waits a programmable settle time, samples z and compares it to the golden value.
- It reports error count, first failing vector and pass/fail.
- It sits between a lab top level / bench and the combinational mux under test, replacing hand-written initial-block stimulus.

Parameters:
- SETTLE_CYC, 2, number of wait cycles between applying a vector and sampling z (0 to 15 legal).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  terminates a sweep in progress.
- mux_a  output  1  datapath input a (registered).
- mux_b  output  1  datapath input b (registered).
- mux_sel  output  1  datapath select c (registered).
- mux_z  input  1  datapath output z.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  one-cycle pulse when a sweep completes normally.
- pass  output  1  high after a completed sweep with zero mismatches; held until next start, abort or reset.
- err_count  output  4  number of mismatching vectors in the current/last sweep, 0 to 8.
- first_fail  output  3  vector index {a,b,sel} of the first mismatch.
- fail_valid  output  1  first_fail holds a captured value.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, vector index v=0.
  - mux_a/mux_b/mux_sel=0, busy=0, done=0, pass=0.
  - err_count=0, first_fail=0, fail_valid=0.
  - Takes effect immediately, including mid-sweep.
- Vector mapping: mux_a=v[2], mux_b=v[1], mux_sel=v[0]. Expected = mux_sel ? mux_b : mux_a.
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> APPLY.
  - On that edge: v=0, outputs driven to vector 0, err_count=0, fail_valid=0, first_fail=0, pass=0.
- APPLY: one cycle. Next state is SETTLE if SETTLE_CYC>0, else SAMPLE.
- SETTLE:
  - A 4-bit down-counter is loaded with SETTLE_CYC-1 on entry.
  - Stays until the counter reaches 0, then -> SAMPLE.
  - Occupancy is exactly SETTLE_CYC cycles.
- SAMPLE: one cycle; mux_z is compared to expected on the clock edge leaving SAMPLE.
  - On mismatch: err_count increments (no saturation needed, max 8).
  - If fail_valid=0, first_fail=v and fail_valid=1.
  - If v==7 -> DONE. Otherwise v increments and the new vector is driven on the same edge -> APPLY.
- DONE: one cycle.
  - done=1; pass=1 iff err_count==0, with the final sample included.
  - Then -> IDLE.
- Cycles per vector: 2+SETTLE_CYC. DONE is entered 8*(2+SETTLE_CYC) cycles after the start edge; done is high in that cycle.
- Mux inputs hold their last value in IDLE/DONE; they are not cleared.
- start while busy or in DONE: ignored, with no effect on the sweep.
- abort, any state other than IDLE:
  - -> IDLE on next edge; done not pulsed; pass=0.
  - err_count/first_fail/fail_valid retain their partial values.
- abort in IDLE: no effect.
- abort and start asserted in the same IDLE cycle: start wins.
- abort and SAMPLE of v==7 in the same cycle: abort wins; no done, pass=0; the sample is still counted.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Correct mux model on mux_z, SETTLE_CYC=2, pulse start -> busy for 32 cycles; done pulses once 32 cycles after start; pass=1, err_count=0, fail_valid=0; mux inputs visit 000..111 in order.
- mux_z tied 0 -> err_count=4 (vectors 3,4,6,7); first_fail=3'b011; fail_valid=1; pass=0; done still pulses.
- mux_z = inverted model -> err_count=8, first_fail=3'b000, pass=0.
- Correct model, abort asserted while v=3 in SETTLE -> IDLE next cycle, busy=0, done never pulses, pass=0, err_count=0.
- Correct model, rst_n pulled low mid-sweep at v=5 -> all outputs 0 immediately; after release a new start completes normally with pass=1.
- SETTLE_CYC=0 build, correct model, second start pulses issued during the sweep -> done exactly 16 cycles after the first start, the extra starts are ignored, pass=1.
